// File: rtl/bht_predictor.sv
// Decode-stage branch predictor: a PC-indexed table of 2-bit saturating counters,
// optionally XOR-hashed with non-speculative global history (gshare).
package bht_pkg;

  typedef enum logic [2:0] {
    OpR,
    OpI,
    OpLoad,
    OpStore,
    OpB,
    OpJ,
    OpLui,
    OpAuipc
  } op_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] raw_instr;
  } fetch_data_t;

  typedef struct packed {
    op_t  op;
    logic alusrc;
    logic branchorjump;
  } control_t;

  typedef struct packed {
    logic [63:0] pc_branch;
    logic        branch;
  } branch_data_t;

endpackage

module bht_predictor
  import bht_pkg::*;
#(
  parameter int unsigned IDX_BITS  = 6,
  parameter int unsigned HIST_BITS = 4,
  parameter bit          GSHARE    = 1'b0,
  parameter logic [1:0]  CNT_INIT  = 2'b01
) (
  input  logic                clk,
  input  logic                reset,
  input  fetch_data_t         pc_instr,
  input  control_t            ctl,
  input  logic [63:0]         imm,
  input  logic [63:0]         srca,
  output branch_data_t        dataPB,
  output logic [IDX_BITS-1:0] pred_idx,
  input  logic                upd_valid,
  input  logic [IDX_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int unsigned Entries = 2 ** IDX_BITS;

  logic [1:0]           cnt_q [Entries];
  logic [HIST_BITS-1:0] ghr_q, ghr_d, ghr_shift;
  logic [IDX_BITS-1:0]  pc_idx;
  logic [1:0]           cnt_rd, upd_cur, upd_next;
  logic [63:0]          b_imm, j_imm, pc_branch;
  logic                 raw_branch;

  assign pc_idx = pc_instr.pc[IDX_BITS+1:2];

  if (GSHARE) begin : g_gshare
    logic [IDX_BITS-1:0] hist_ext;
    assign hist_ext = IDX_BITS'(ghr_q);
    assign pred_idx = pc_idx ^ hist_ext;
  end else begin : g_bimodal
    assign pred_idx = pc_idx;
  end

  // A one-bit history has no older bits to keep, so the shift degenerates to a load.
  if (HIST_BITS > 1) begin : g_hist_shift
    assign ghr_shift = {ghr_q[HIST_BITS-2:0], upd_taken};
  end else begin : g_hist_load
    assign ghr_shift = upd_taken;
  end

  always_comb begin
    ghr_d = ghr_q;
    if (upd_valid) ghr_d = ghr_shift;
  end

  // Immediates decoded straight from the raw instruction, sign-extended to 64 bits.
  assign b_imm = {{51{pc_instr.raw_instr[31]}}, pc_instr.raw_instr[31], pc_instr.raw_instr[7],
                  pc_instr.raw_instr[30:25], pc_instr.raw_instr[11:8], 1'b0};
  assign j_imm = {{43{pc_instr.raw_instr[31]}}, pc_instr.raw_instr[31],
                  pc_instr.raw_instr[19:12], pc_instr.raw_instr[20],
                  pc_instr.raw_instr[30:21], 1'b0};

  assign cnt_rd = cnt_q[pred_idx];

  always_comb begin
    raw_branch = 1'b0;
    pc_branch  = '0;
    case (ctl.op)
      OpB: begin
        raw_branch = cnt_rd[1];
        pc_branch  = pc_instr.pc + b_imm;
      end
      OpJ: begin
        raw_branch = 1'b1;
        if (ctl.alusrc) pc_branch = (imm + srca) & ~64'h1;
        else            pc_branch = pc_instr.pc + j_imm;
      end
      default: ;
    endcase
  end

  assign dataPB.pc_branch = pc_branch;
  assign dataPB.branch    = raw_branch & ctl.branchorjump;

  assign upd_cur = cnt_q[upd_idx];

  always_comb begin
    upd_next = upd_cur;
    if (upd_taken) begin
      if (upd_cur != 2'b11) upd_next = upd_cur + 2'd1;
    end else begin
      if (upd_cur != 2'b00) upd_next = upd_cur - 2'd1;
    end
  end

  // Lookups read cnt_q directly, so a same-cycle update is only seen next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < Entries; i++) cnt_q[i] <= CNT_INIT;
      ghr_q <= '0;
    end else begin
      if (upd_valid) cnt_q[upd_idx] <= upd_next;
      ghr_q <= ghr_d;
    end
  end

  // Opcode bits are decoded upstream; history is only consumed in gshare mode.
  logic unused_bits;
  assign unused_bits = ^{pc_instr.raw_instr[6:0], ghr_q};

endmodule

// File: tb/tb_bht_predictor.sv
// Directed bench for bht_predictor: a bimodal instance plus a gshare instance.
module tb_bht_predictor;
  import bht_pkg::*;

  localparam logic [31:0] BeqM8 = 32'hFE000CE3;
  localparam logic [31:0] JalP8 = 32'h008000EF;

  logic         clk = 1'b0;
  logic         reset;
  fetch_data_t  pc_instr, g_pc_instr;
  control_t     ctl;
  logic [63:0]  imm, srca;
  branch_data_t dataPB, g_dataPB;
  logic [5:0]   pred_idx, g_pred_idx;
  logic         upd_valid, upd_taken, g_upd_valid, g_upd_taken;
  logic [5:0]   upd_idx, g_upd_idx;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bht_predictor #(.IDX_BITS(6), .HIST_BITS(4), .GSHARE(1'b0), .CNT_INIT(2'b01)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_instr  (pc_instr),
    .ctl       (ctl),
    .imm       (imm),
    .srca      (srca),
    .dataPB    (dataPB),
    .pred_idx  (pred_idx),
    .upd_valid (upd_valid),
    .upd_idx   (upd_idx),
    .upd_taken (upd_taken)
  );

  bht_predictor #(.IDX_BITS(6), .HIST_BITS(4), .GSHARE(1'b1), .CNT_INIT(2'b01)) dut_g (
    .clk       (clk),
    .reset     (reset),
    .pc_instr  (g_pc_instr),
    .ctl       (ctl),
    .imm       (imm),
    .srca      (srca),
    .dataPB    (g_dataPB),
    .pred_idx  (g_pred_idx),
    .upd_valid (g_upd_valid),
    .upd_idx   (g_upd_idx),
    .upd_taken (g_upd_taken)
  );

  // Inputs change 1 time unit after the rising edge; checks follow another unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup_b(input logic [63:0] pc);
    pc_instr.pc        = pc;
    pc_instr.raw_instr = BeqM8;
    ctl.op             = OpB;
    ctl.alusrc         = 1'b0;
    ctl.branchorjump   = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    cyc();
    lookup_b(64'h0);
    n_cmp++;
    if (dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during: branch got %0b expected 0", dataPB.branch);
    end
    reset = 1'b0;
    cyc();
    for (int i = 0; i < 64; i++) begin
      lookup_b(64'(i * 4));
      n_cmp++;
      if (dataPB.branch !== 1'b0 || pred_idx !== 6'(i)) begin
        n_fail++;
        $display("FAIL reset_entry[%0d]: branch/idx got %0b/%0d expected 0/%0d",
                 i, dataPB.branch, pred_idx, i);
      end
    end
  endtask

  task automatic test_beq();
    lookup_b(64'h8000_0000);
    n_cmp++;
    if (dataPB.pc_branch !== 64'h7FFF_FFF8 || pred_idx !== 6'd0 || dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL beq_target: tgt/idx/br got %h/%0d/%0b expected 7ffffff8/0/0",
               dataPB.pc_branch, pred_idx, dataPB.branch);
    end
    upd_valid = 1'b1;
    upd_idx   = 6'd0;
    upd_taken = 1'b1;
    cyc();
    cyc();
    upd_valid = 1'b0;
    #1;
    n_cmp++;
    if (dataPB.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL beq_trained: branch got %0b expected 1", dataPB.branch);
    end
    lookup_b(64'h0);
    n_cmp++;
    if (dataPB.pc_branch !== 64'hFFFF_FFFF_FFFF_FFF8) begin
      n_fail++;
      $display("FAIL beq_wrap: tgt got %h expected fffffffffffffff8", dataPB.pc_branch);
    end
  endtask

  task automatic test_saturate();
    logic [4:0] dirs = 5'b11100;
    logic [4:0] exp  = 5'b11110;
    lookup_b(64'h14);
    upd_idx = 6'd5;
    for (int k = 4; k >= 0; k--) begin
      upd_valid = 1'b1;
      upd_taken = dirs[k];
      cyc();
      upd_valid = 1'b0;
      #1;
      n_cmp++;
      if (dataPB.branch !== exp[k]) begin
        n_fail++;
        $display("FAIL saturate_step[%0d]: branch got %0b expected %0b", 4 - k,
                 dataPB.branch, exp[k]);
      end
    end
  endtask

  task automatic test_same_cycle();
    lookup_b(64'h24);
    upd_valid = 1'b1;
    upd_idx   = 6'd9;
    upd_taken = 1'b1;
    #1;
    n_cmp++;
    if (dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL same_cycle_pre: branch got %0b expected 0", dataPB.branch);
    end
    cyc();
    upd_valid = 1'b0;
    #1;
    n_cmp++;
    if (dataPB.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL same_cycle_post: branch got %0b expected 1", dataPB.branch);
    end
  endtask

  task automatic test_gshare();
    logic [3:0] dirs = 4'b1011;
    logic [5:0] exp_idx [4] = '{6'h05, 6'h06, 6'h01, 6'h0F};
    g_pc_instr.pc        = 64'h10;
    g_pc_instr.raw_instr = BeqM8;
    ctl.op               = OpB;
    ctl.branchorjump     = 1'b1;
    #1;
    n_cmp++;
    if (g_pred_idx !== 6'h04) begin
      n_fail++;
      $display("FAIL gshare_idx_init: got %h expected 04", g_pred_idx);
    end
    g_upd_idx = 6'h3F;
    for (int k = 0; k < 4; k++) begin
      g_upd_valid = 1'b1;
      g_upd_taken = dirs[3-k];
      cyc();
      g_upd_valid = 1'b0;
      #1;
      n_cmp++;
      if (g_pred_idx !== exp_idx[k]) begin
        n_fail++;
        $display("FAIL gshare_idx[%0d]: got %h expected %h", k, g_pred_idx, exp_idx[k]);
      end
    end
    n_cmp++;
    if (g_dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL gshare_branch: got %0b expected 0", g_dataPB.branch);
    end
  endtask

  task automatic test_jump();
    pc_instr.pc        = 64'h1000;
    pc_instr.raw_instr = JalP8;
    ctl.op             = OpJ;
    ctl.alusrc         = 1'b0;
    ctl.branchorjump   = 1'b1;
    #1;
    n_cmp++;
    if (dataPB.pc_branch !== 64'h1008 || dataPB.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL jal: tgt/br got %h/%0b expected 1008/1", dataPB.pc_branch, dataPB.branch);
    end
    ctl.alusrc = 1'b1;
    imm        = 64'd3;
    srca       = 64'h1000;
    #1;
    n_cmp++;
    if (dataPB.pc_branch !== 64'h1002 || dataPB.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL jalr: tgt/br got %h/%0b expected 1002/1", dataPB.pc_branch, dataPB.branch);
    end
    ctl.branchorjump = 1'b0;
    #1;
    n_cmp++;
    if (dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL jalr_gated: branch got %0b expected 0", dataPB.branch);
    end
    ctl.branchorjump = 1'b1;
    imm              = 64'hFFFF_FFFF_FFFF_FFFF;
    srca             = 64'd2;
    #1;
    n_cmp++;
    if (dataPB.pc_branch !== 64'h0) begin
      n_fail++;
      $display("FAIL jalr_wrap: tgt got %h expected 0", dataPB.pc_branch);
    end
    ctl.op = OpR;
    #1;
    n_cmp++;
    if (dataPB.pc_branch !== 64'h0 || dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL other_op: tgt/br got %h/%0b expected 0/0", dataPB.pc_branch, dataPB.branch);
    end
  endtask

  task automatic test_reset_override();
    reset     = 1'b1;
    upd_valid = 1'b1;
    upd_idx   = 6'd9;
    upd_taken = 1'b1;
    cyc();
    cyc();
    reset     = 1'b0;
    upd_valid = 1'b0;
    lookup_b(64'h24);
    n_cmp++;
    if (dataPB.branch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_override: branch got %0b expected 0", dataPB.branch);
    end
    upd_valid = 1'b1;
    cyc();
    upd_valid = 1'b0;
    #1;
    n_cmp++;
    if (dataPB.branch !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_value_01: branch got %0b expected 1", dataPB.branch);
    end
  endtask

  initial begin
    reset       = 1'b1;
    pc_instr    = '0;
    g_pc_instr  = '0;
    ctl         = '{op: OpR, alusrc: 1'b0, branchorjump: 1'b0};
    imm         = '0;
    srca        = '0;
    upd_valid   = 1'b0;
    upd_idx     = '0;
    upd_taken   = 1'b0;
    g_upd_valid = 1'b0;
    g_upd_idx   = '0;
    g_upd_taken = 1'b0;
    cyc();
    test_reset();
    test_beq();
    test_saturate();
    test_same_cycle();
    test_gshare();
    test_jump();
    test_reset_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
